uart_rx_sampler: RTL and testbench

Oversampling bit-recovery stage of the UART receiver. Counts `Prescale` clock edges per bit, majority-votes the oversampled `RX_IN` around the bit centre, and presents one recovered bit per bit period with a valid strobe and bit index. Sits between the receiver FSM (which drives `sample_EN` and `par_EN`) and the start/parity/stop checkers, which consume `sampled_bit` qualified by `bit_valid` and `bit_cnt`.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/edge_bit_counter.sv | 56 +++++
 rtl/uart_rx_sampler.sv | 88 ++++++++
 tb/tb_uart_rx_sampler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: counter widths, frame
// lengths and the 3-sample vote helper used by the bit sampler.
package uart_rx_pkg;

  localparam int PRESCALE_W_DEF  = 6;
  localparam int BIT_CNT_W       = 4;
  localparam int FRAME_LEN_NOPAR = 10;
  localparam int FRAME_LEN_PAR   = 11;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Two-of-three vote; rejects a single-cycle glitch at the bit centre.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Edge/bit position counters for the UART bit sampler. edge_cnt walks
// through one bit period of Prescale clocks; bit_cnt walks through the
// frame and frame_done pulses once when the final bit period ends.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sample_EN,
  input  logic                  par_EN,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output bit_cnt_t              bit_cnt,
  output logic                  frame_done
);

  logic [PRESCALE_W-1:0] last_edge;
  logic                  edge_wrap;
  bit_cnt_t              last_bit;

  // >= rather than == so a Prescale changed under a running count still
  // forces a wrap instead of counting all the way round.
  assign last_edge = Prescale - 1'b1;
  assign edge_wrap = (edge_cnt >= last_edge);
  assign last_bit  = par_EN ? bit_cnt_t'(FRAME_LEN_PAR - 1)
                            : bit_cnt_t'(FRAME_LEN_NOPAR - 1);

  // Advance edge/bit position while enabled; clear when the receiver idles.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (!sample_EN) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (edge_wrap) begin
        edge_cnt <= '0;
        if (bit_cnt >= last_bit) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling bit recovery for the UART receiver. Samples RX_IN at
// edge_cnt = half-1 and half, then at half+1 resolves the bit and strobes
// bit_valid. With UART_RX_SAMPLER_MAJORITY_EN defined the bit is a 3-sample
// majority (half-1, half, half+1); otherwise it is the single centre sample
// taken at half. Strobe timing is the same in both builds.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sample_EN,
  input  logic                  par_EN,
  output logic                  sampled_bit,
  output logic                  bit_valid,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  frame_done
);

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] samp_lo;
  logic [PRESCALE_W-1:0] samp_hi;
  logic                  s1;
  logic                  vote;

  assign half    = Prescale >> 1;
  assign samp_lo = half - 1'b1;
  assign samp_hi = half + 1'b1;

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_edge_bit_counter (
    .CLK        (CLK),
    .Reset      (Reset),
    .Prescale   (Prescale),
    .sample_EN  (sample_EN),
    .par_EN     (par_EN),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done)
  );

`ifdef UART_RX_SAMPLER_MAJORITY_EN
  logic s0;

  // Early sample, one clock before the bit centre.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s0 <= 1'b1;
    end else if (sample_EN && (edge_cnt == samp_lo)) begin
      s0 <= RX_IN;
    end
  end

  assign vote = maj3(s0, s1, RX_IN);
`else
  assign vote = s1;
`endif

  // Centre sample.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b1;
    end else if (sample_EN && (edge_cnt == half)) begin
      s1 <= RX_IN;
    end
  end

  // Resolve the bit one clock after the centre and strobe it for one cycle;
  // sampled_bit holds between strobes and while disabled.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sampled_bit <= 1'b1;
      bit_valid   <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (sample_EN && (edge_cnt == samp_hi)) begin
        sampled_bit <= vote;
        bit_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          sample_EN;
  logic          par_EN;
  logic          sampled_bit;
  logic          bit_valid;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] edge_cnt;
  logic          frame_done;

  uart_rx_sampler #(.PRESCALE_W(PW)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .sample_EN   (sample_EN),
    .par_EN      (par_EN),
    .sampled_bit (sampled_bit),
    .bit_valid   (bit_valid),
    .bit_cnt     (bit_cnt),
    .edge_cnt    (edge_cnt),
    .frame_done  (frame_done)
  );

  always #5 CLK = ~CLK;

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;
  int   P;
  int   L;
  int   k;
  logic exp_sb;
  logic rx_hist [0:1023];

  // Recovered bit value from the three line samples around the bit centre.
  function automatic logic ref_bit(input logic a, input logic b, input logic c);
`ifdef UART_RX_SAMPLER_MAJORITY_EN
    return ((int'(a) + int'(b) + int'(c)) >= 2);
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d P=%0d)", tag, obs, exp, k, P);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    check("rst_bit_valid",   32'(bit_valid),   32'd0);
    check("rst_bit_cnt",     32'(bit_cnt),     32'd0);
    check("rst_edge_cnt",    32'(edge_cnt),    32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
  endtask

  // One clock: k counts enabled edges since enable; bit b occupies enabled
  // cycles b*P .. b*P+P-1 and its strobe appears at offset half+2.
  task automatic step(input logic en, input logic rx);
    int h;
    int base;
    int e_edge;
    int e_bit;
    int e_bv;
    int e_fd;
    sample_EN = en;
    RX_IN     = rx;
    if (en && k < 1024) rx_hist[k] = rx;
    @(posedge CLK);
    #1;
    h = P / 2;
    if (en) begin
      k++;
      e_edge = k % P;
      e_bit  = (k / P) % L;
      e_bv   = ((k % P) == h + 2) ? 1 : 0;
      e_fd   = ((k % (L * P)) == 0) ? 1 : 0;
      if (e_bv != 0) begin
        base   = k - (k % P);
        exp_sb = ref_bit(rx_hist[base + h - 1], rx_hist[base + h], rx_hist[base + h + 1]);
      end
    end else begin
      k      = 0;
      e_edge = 0;
      e_bit  = 0;
      e_bv   = 0;
      e_fd   = 0;
    end
    check("edge_cnt",    32'(edge_cnt),    32'(e_edge));
    check("bit_cnt",     32'(bit_cnt),     32'(e_bit));
    check("bit_valid",   32'(bit_valid),   32'(e_bv));
    check("frame_done",  32'(frame_done),  32'(e_fd));
    check("sampled_bit", 32'(sampled_bit), 32'(exp_sb));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    sample_EN = 1'b0;
    RX_IN     = 1'b1;
    par_EN    = 1'b0;
    Prescale  = PW'(8);
    P         = 8;
    L         = 10;
    k         = 0;
    exp_sb    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals();
    Reset = 1'b0;

    // Prescale 8, no parity, line held low: full frame plus a little.
    for (int i = 0; i < 84; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Prescale 8 with parity, random line.
    par_EN = 1'b1;
    L      = 11;
    for (int i = 0; i < 92; i++) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1);

    // Prescale 16: single-cycle low glitch exactly at the bit centre.
    par_EN   = 1'b0;
    L        = 10;
    Prescale = PW'(16);
    P        = 16;
    for (int i = 0; i < 165; i++) step(1'b1, ((i % 16) == 8) ? 1'b0 : 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 48; i++) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1);

    // Prescale 32, random line.
    Prescale = PW'(32);
    P        = 32;
    for (int i = 0; i < 100; i++) step(1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b1);

    // Drop enable at bit_cnt=3, edge_cnt=2.
    Prescale = PW'(8);
    P        = 8;
    for (int i = 0; i < 26; i++) step(1'b1, 1'($urandom_range(0, 1)));
    check("drop_pre_bit_cnt",  32'(bit_cnt),  32'd3);
    check("drop_pre_edge_cnt", 32'(edge_cnt), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-bit, then restart from a fresh enable.
    for (int i = 0; i < 13; i++) step(1'b1, 1'($urandom_range(0, 1)));
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals();
    k      = 0;
    exp_sb = 1'b1;
    #3;
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
